// File: rtl/psum_tile_accumulator.sv
// Accumulates N_SIZE-row psum tiles over K-passes with per-lane signed saturation,
// then drains the finished tile row by row over a valid/ready handshake.
module psum_tile_accumulator #(
  parameter int unsigned DATA_W_OUT = 32,
  parameter int unsigned N_SIZE     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_SIZE-1:0][DATA_W_OUT-1:0]     psum_in,
  input  logic                                  in_valid,
  input  logic                                  in_first,
  input  logic                                  in_last,
  output logic                                  in_ready,
  output logic [N_SIZE-1:0][DATA_W_OUT-1:0]     out_data,
  output logic [$clog2(N_SIZE)-1:0]             out_row,
  output logic                                  out_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  ovf
);

  localparam int unsigned CNT_W = $clog2(N_SIZE);
  localparam logic [DATA_W_OUT-1:0] SAT_MAX = {1'b0, {(DATA_W_OUT-1){1'b1}}};
  localparam logic [DATA_W_OUT-1:0] SAT_MIN = {1'b1, {(DATA_W_OUT-1){1'b0}}};

  typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

  state_t state_q, state_d;

  logic [N_SIZE-1:0][DATA_W_OUT-1:0] buf_q [N_SIZE];
  logic [CNT_W-1:0]                  wr_cnt, rd_cnt;
  logic                              first_q, last_q;
  logic                              beat, xfer;
  logic                              wr_last, rd_last;
  logic                              eff_first, eff_last;
  logic                              sat_any;
  logic [DATA_W_OUT:0]               lane_sum;
  logic [N_SIZE-1:0][DATA_W_OUT-1:0] sum_row, wr_row;

  assign wr_last = (wr_cnt == CNT_W'(N_SIZE - 1));
  assign rd_last = (rd_cnt == CNT_W'(N_SIZE - 1));

  // Tile flags are live on the row-0 beat and held for the remaining rows.
  assign eff_first = (wr_cnt == '0) ? in_first : first_q;
  assign eff_last  = (wr_cnt == '0) ? in_last  : last_q;

  // Per-lane saturating add of the incoming row onto the stored row.
  always_comb begin
    sum_row  = '0;
    sat_any  = 1'b0;
    lane_sum = '0;
    for (int j = 0; j < int'(N_SIZE); j++) begin
      lane_sum = {buf_q[wr_cnt][j][DATA_W_OUT-1], buf_q[wr_cnt][j]}
               + {psum_in[j][DATA_W_OUT-1], psum_in[j]};
      if (lane_sum[DATA_W_OUT] != lane_sum[DATA_W_OUT-1]) begin
        sat_any    = 1'b1;
        sum_row[j] = lane_sum[DATA_W_OUT] ? SAT_MIN : SAT_MAX;
      end else begin
        sum_row[j] = lane_sum[DATA_W_OUT-1:0];
      end
    end
  end

  assign wr_row = eff_first ? psum_in : sum_row;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Next state and handshake decode; both handshakes are held off during reset.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    beat      = 1'b0;
    xfer      = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = !rst;
        beat     = in_valid && !rst;
        if (beat && wr_last && eff_last) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = !rst;
        xfer      = out_ready && !rst;
        if (xfer && rd_last) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Counters, held tile flags and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (beat) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + CNT_W'(1);
        if (wr_cnt == '0) begin
          first_q <= in_first;
          last_q  <= in_last;
        end
        if (wr_cnt == '0 && in_first) ovf <= 1'b0;
        else if (!eff_first && sat_any) ovf <= 1'b1;
        if (wr_last && eff_last) rd_cnt <= '0;
      end
      if (xfer) rd_cnt <= rd_last ? '0 : rd_cnt + CNT_W'(1);
    end
  end

  // Tile buffer is intentionally not reset; a first-flagged tile always overwrites it.
  always_ff @(posedge clk) begin
    if (beat) buf_q[wr_cnt] <= wr_row;
  end

  assign out_data = buf_q[rd_cnt];
  assign out_row  = rst ? '0 : rd_cnt;
  assign out_last = out_valid && rd_last;

endmodule

// File: tb/tb_psum_tile_accumulator.sv
// Randomized self-checking bench for psum_tile_accumulator against a tile-level
// reference model (per-row lane arrays with saturating integer arithmetic).
module tb_psum_tile_accumulator;

  localparam int DW = 32;
  localparam int N  = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic                  clk, rst;
  logic [N-1:0][DW-1:0]  psum_in;
  logic                  in_valid, in_first, in_last, in_ready;
  logic [N-1:0][DW-1:0]  out_data;
  logic [3:0]            out_row;
  logic                  out_last, out_valid, out_ready, ovf;

  psum_tile_accumulator #(.DATA_W_OUT(DW), .N_SIZE(N)) dut (
    .clk(clk), .rst(rst), .psum_in(psum_in), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [DW-1:0] tile_vals [N][N];
  longint               exp_buf   [N][N];
  bit                   exp_ovf;

  logic [DW-1:0] got_data [N][N];
  int            got_row  [N];
  bit            got_last [N];
  int            n_got, viol, low_cnt;
  bit            ready_after, timed_out;

  // Drive one tile pass (N back-to-back beats) and fold it into the model.
  task automatic send_tile(input bit first, input bit last);
    longint s;
    if (first) exp_ovf = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        psum_in[j] = tile_vals[r][j];
        if (first) exp_buf[r][j] = longint'(tile_vals[r][j]);
        else begin
          s = exp_buf[r][j] + longint'(tile_vals[r][j]);
          if (s > MAXV) begin s = MAXV; exp_ovf = 1'b1; end
          else if (s < MINV) begin s = MINV; exp_ovf = 1'b1; end
          exp_buf[r][j] = s;
        end
      end
      in_first = (r == 0) ? first : 1'($urandom);
      in_last  = (r == 0) ? last  : 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Capture drained rows; records stall stability violations and in_ready-low cycles.
  task automatic collect_drain(input bit bp, input bit inject, input int max_rows);
    logic [N-1:0][DW-1:0] snap_d;
    logic [3:0]           snap_r;
    logic                 snap_l;
    bit                   stalled;
    int                   budget;
    n_got = 0; viol = 0; low_cnt = 0; stalled = 1'b0; budget = 0; timed_out = 1'b0;
    while (n_got < max_rows) begin
      if (budget >= 300) begin timed_out = 1'b1; break; end
      budget++;
      out_ready = bp ? 1'($urandom % 2) : 1'b1;
      if (inject) begin
        in_valid = 1'($urandom % 2);
        in_first = 1'b1;
        in_last  = 1'b1;
        for (int j = 0; j < N; j++) psum_in[j] = $urandom;
      end
      #0;
      if (!in_ready) low_cnt++;
      if (stalled && out_valid && (out_data !== snap_d || out_row !== snap_r || out_last !== snap_l))
        viol++;
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        for (int j = 0; j < N; j++) got_data[n_got][j] = out_data[j];
        got_row[n_got]  = int'(out_row);
        got_last[n_got] = out_last;
        n_got++;
      end else if (out_valid) begin
        snap_d = out_data; snap_r = out_row; snap_l = out_last; stalled = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    ready_after = in_ready;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_row !== 4'd0 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: in_ready=%0b out_valid=%0b out_row=%0d out_last=%0b want 0 0 0 0",
               in_ready, out_valid, out_row, out_last);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b ovf=%0b want 1 0 0",
               in_ready, out_valid, ovf);
    end
  endtask

  task automatic test_single_pass();
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) tile_vals[r][j] = DW'(16 * r + j);
    send_tile(1'b1, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL sp_latency: out_valid=%0b in_ready=%0b want 1 0", out_valid, in_ready);
    end
    collect_drain(1'b0, 1'b0, N);
    n_cmp++;
    if (timed_out || n_got != N || low_cnt != N || ready_after !== 1'b1) begin
      n_err++;
      $display("FAIL sp_drain: rows=%0d low=%0d ready_after=%0b timeout=%0b want %0d %0d 1 0",
               n_got, low_cnt, ready_after, timed_out, N, N);
    end
    for (int r = 0; r < n_got; r++) begin
      n_cmp++;
      if (got_row[r] != r || got_last[r] != (r == N - 1)) begin
        n_err++;
        $display("FAIL sp_row%0d: row=%0d last=%0b want row=%0d last=%0b",
                 r, got_row[r], got_last[r], r, (r == N - 1));
      end
      for (int j = 0; j < N; j++) begin
        n_cmp++;
        if (got_data[r][j] !== DW'(16 * r + j)) begin
          n_err++;
          $display("FAIL sp_data r%0d l%0d: got %h want %h", r, j, got_data[r][j], DW'(16 * r + j));
        end
      end
    end
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL sp_ovf: got %0b want 0", ovf); end
  endtask

  task automatic test_three_pass();
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) tile_vals[r][j] = DW'(5);
    send_tile(1'b1, 1'b0);
    send_tile(1'b0, 1'b0);
    send_tile(1'b0, 1'b1);
    collect_drain(1'b0, 1'b0, N);
    n_cmp++;
    if (timed_out || n_got != N || low_cnt != 16 || ready_after !== 1'b1) begin
      n_err++;
      $display("FAIL tp_drain: rows=%0d low=%0d ready_after=%0b want %0d 16 1", n_got, low_cnt, ready_after, N);
    end
    for (int r = 0; r < n_got; r++) for (int j = 0; j < N; j++) begin
      n_cmp++;
      if (got_data[r][j] !== DW'(15)) begin
        n_err++;
        $display("FAIL tp_data r%0d l%0d: got %0d want 15", r, j, got_data[r][j]);
      end
    end
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL tp_ovf: got %0b want 0", ovf); end
  endtask

  task automatic test_saturation(input bit neg);
    logic [DW-1:0] a, b, want;
    a    = neg ? 32'h8000_0005 : 32'h7FFF_FFF0;
    b    = neg ? 32'hFFFF_FFF0 : 32'h0000_0020;
    want = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) tile_vals[r][j] = a;
    send_tile(1'b1, 1'b0);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) tile_vals[r][j] = b;
    send_tile(1'b0, 1'b1);
    collect_drain(1'b0, 1'b0, N);
    n_cmp++;
    if (timed_out || n_got != N) begin
      n_err++; $display("FAIL sat%0b_drain: rows=%0d want %0d", neg, n_got, N);
    end
    for (int r = 0; r < n_got; r++) for (int j = 0; j < N; j++) begin
      n_cmp++;
      if (got_data[r][j] !== want) begin
        n_err++;
        $display("FAIL sat%0b_data r%0d l%0d: got %h want %h", neg, r, j, got_data[r][j], want);
      end
    end
    n_cmp++;
    if (ovf !== 1'b1) begin n_err++; $display("FAIL sat%0b_ovf_set: got %0b want 1", neg, ovf); end
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) tile_vals[r][j] = DW'(r);
    send_tile(1'b1, 1'b1);
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL sat%0b_ovf_clear: got %0b want 0", neg, ovf); end
    collect_drain(1'b0, 1'b0, N);
  endtask

  task automatic test_random_backpressure();
    int k;
    for (int t = 0; t < 4; t++) begin
      k = int'($urandom_range(3, 1));
      for (int p = 0; p < k; p++) begin
        for (int r = 0; r < N; r++) for (int j = 0; j < N; j++)
          tile_vals[r][j] = ($urandom % 2) ? DW'($urandom) : DW'($urandom_range(2000)) - DW'(1000);
        send_tile(p == 0, p == k - 1);
      end
      collect_drain(1'b1, 1'b1, N);
      n_cmp++;
      if (timed_out || n_got != N || viol != 0 || ready_after !== 1'b1) begin
        n_err++;
        $display("FAIL bp%0d_drain: rows=%0d stall_viol=%0d ready_after=%0b want %0d 0 1",
                 t, n_got, viol, ready_after, N);
      end
      for (int r = 0; r < n_got; r++) begin
        n_cmp++;
        if (got_row[r] != r || got_last[r] != (r == N - 1)) begin
          n_err++;
          $display("FAIL bp%0d_row%0d: row=%0d last=%0b want row=%0d", t, r, got_row[r], got_last[r], r);
        end
        for (int j = 0; j < N; j++) begin
          n_cmp++;
          if (got_data[r][j] !== DW'(exp_buf[r][j])) begin
            n_err++;
            $display("FAIL bp%0d_data r%0d l%0d: got %h want %h", t, r, j, got_data[r][j], DW'(exp_buf[r][j]));
          end
        end
      end
      n_cmp++;
      if (ovf !== exp_ovf) begin n_err++; $display("FAIL bp%0d_ovf: got %0b want %0b", t, ovf, exp_ovf); end
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) tile_vals[r][j] = DW'($urandom);
    send_tile(1'b1, 1'b1);
    collect_drain(1'b0, 1'b0, 8);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rmd_in_reset: out_valid=%0b in_ready=%0b want 0 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ovf = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL rmd_after: in_ready=%0b out_valid=%0b ovf=%0b want 1 0 0", in_ready, out_valid, ovf);
    end
    @(posedge clk); #1;
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) tile_vals[r][j] = DW'($urandom);
    send_tile(1'b1, 1'b1);
    collect_drain(1'b0, 1'b0, N);
    n_cmp++;
    if (timed_out || n_got != N) begin n_err++; $display("FAIL rmd_drain: rows=%0d want %0d", n_got, N); end
    for (int r = 0; r < n_got; r++) begin
      n_cmp++;
      if (got_row[r] != r) begin n_err++; $display("FAIL rmd_row%0d: got %0d want %0d", r, got_row[r], r); end
      for (int j = 0; j < N; j++) begin
        n_cmp++;
        if (got_data[r][j] !== DW'(exp_buf[r][j])) begin
          n_err++;
          $display("FAIL rmd_data r%0d l%0d: got %h want %h", r, j, got_data[r][j], DW'(exp_buf[r][j]));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; psum_in = '0; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_pass();
    test_three_pass();
    test_saturation(1'b0);
    test_saturation(1'b1);
    test_random_backpressure();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
